debounce_edge: RTL and testbench
================================

# debounce_edge

Debounce and edge-detect stage for one push-button or switch input. Sits directly downstream of the two-flop input synchronizer and consumes its already-synchronized level. Produces a clean debounced level, single-cycle rise/fall pulses for control FSMs, and an optional long-press pulse. One instance per button.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a level change; legal range ≥ 1.
- `LONG_CYCLES`, default 10000000: cycles in the accepted-high state before `long_press` fires; legal range ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `in` in 1: synchronized button level from the synchronizer stage.
- `out` out 1: debounced level.
- `rise` out 1: one-cycle pulse when `out` goes 0→1.
- `fall` out 1: one-cycle pulse when `out` goes 1→0.
- `long_press` out 1: one-cycle pulse, at most once per press; tied 0 when the feature is compiled out.

## Operation
- Every output is a register. There is no combinational path from `in` to any output.
- Debounce counter `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`.
- The FSM has four states:
  - LOW: `out`=0. If `in`=1, go to ARM_H with `cnt`=0.
  - ARM_H: `out`=0.
    - If `in`=0, return to LOW. No pulse; the glitch is rejected.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to HIGH, set `out`=1, pulse `rise`.
    - Else `cnt`++.
  - HIGH: `out`=1. If `in`=0, go to ARM_L with `cnt`=0.
  - ARM_L: `out`=1.
    - If `in`=1, return to HIGH. No pulse.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to LOW, set `out`=0, pulse `fall`.
    - Else `cnt`++.
- `rise` and `fall` are never high in the same cycle. Each is high for exactly one cycle per accepted transition.
- A bounce during ARM_x restarts the debounce window from scratch on the next attempt. There is no partial credit.
- Reset (`rst`=1 at a clock edge):
  - State goes to LOW; `cnt`, the hold counter, `out`, `rise`, `fall` and `long_press` all go to 0.
  - `rst` has priority over every other condition, including an in-flight debounce or a pending pulse.
- If `in` is held 1 through reset, a full debounce runs after reset and `rise` fires. This is intended: downstream logic sees the press.

## Timing
- Let edge t be the first edge that samples `in`=1 while in LOW.
- `out`=1 and `rise`=1 become visible after edge t+DEBOUNCE_CYCLES. This requires `in`=1 at every edge from t through t+DEBOUNCE_CYCLES.
- `rise` deasserts at edge t+DEBOUNCE_CYCLES+1.
- The falling direction is symmetric: `fall` is visible DEBOUNCE_CYCLES edges after the first edge that samples `in`=0 in HIGH.
- With DEBOUNCE_CYCLES=1, a change must be seen on two consecutive edges.
- Total latency from the pin is 2 cycles (synchronizer) plus DEBOUNCE_CYCLES.

## Configuration
- Macro: `DEBOUNCE_LONG_PRESS_EN`.
- When defined:
  - A hold counter of width `$clog2(LONG_CYCLES+1)` clears on the entry edge into HIGH from ARM_H.
  - It increments every cycle in HIGH and ARM_L, and saturates at LONG_CYCLES.
  - On the edge where it reaches LONG_CYCLES, `long_press` pulses for one cycle. There is no further pulse until the counter is cleared again.
  - A bounce ARM_L→HIGH does not clear the counter. Entering LOW clears it.
- When undefined:
  - The hold counter is not instantiated.
  - `long_press` is constant 0.
  - The port remains present so the interface is identical in both builds.

## Test plan
Parameters for all directed tests: DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
- **Reset values:** assert `rst` for 2 cycles with `in`=1 → `out`, `rise`, `fall`, `long_press` all 0 during reset. `rise` pulses exactly once, at the 4th edge after the first post-reset edge sampling 1.
- **Clean press/release:** `in` 0→1 held 10 cycles, then 0 → `rise` is high one cycle, 4 edges after the first sample of 1; `out`=1. `fall` pulses 4 edges after the first sample of 0; `out`=0.
- **Glitch reject:** `in` pattern 1,1,1,0 then 1×6 → no pulse from the first burst. `rise` fires 4 edges after the restart edge.
- **Release bounce:** in HIGH, `in` goes 0,0,1 then stays 1 → `out` stays 1 throughout; no `fall`, no second `rise`.
- **Long press (macro defined):** hold `in`=1 for 40 cycles → exactly one `long_press` pulse, 20 cycles after `rise`. With the macro undefined, `long_press` stays 0 for the whole run.
- **Reset mid-debounce:** assert `rst` while in ARM_H with `cnt`=2 → `out`=0 and no `rise`. After release of `rst`, a fresh 4-cycle window is required.

Source files
------------

// File: rtl/debounce_edge_if.sv
// Button-side signal bundle for debounce_edge: synchronized level in, clean level and pulses out.
interface debounce_edge_if;
  logic in;
  logic out;
  logic rise;
  logic fall;
  logic long_press;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall,
    input  long_press
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall,
    output long_press
  );
endinterface

// File: rtl/debounce_edge.sv
// Debounce and edge-detect for one synchronized button level, all outputs registered.
// Define DEBOUNCE_LONG_PRESS_EN to build the long-press hold counter; otherwise long_press is 0.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned LONG_CYCLES     = 10000000
) (
  input logic            clk,
  input logic            rst,
  debounce_edge_if.slave btn
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StLow, StArmH, StHigh, StArmL} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLow;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A bounce back to the settled state drops the window; the next attempt starts at cnt 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (btn.in) begin
          state_d = StArmH;
          cnt_d   = '0;
        end
      end
      StArmH: begin
        if (!btn.in) begin
          state_d = StLow;
        end else if (cnt_q == CntMax) begin
          state_d = StHigh;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!btn.in) begin
          state_d = StArmL;
          cnt_d   = '0;
        end
      end
      StArmL: begin
        if (btn.in) begin
          state_d = StHigh;
        end else if (cnt_q == CntMax) begin
          state_d = StLow;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLow;
    endcase
  end

  assign btn.out  = out_q;
  assign btn.rise = rise_q;
  assign btn.fall = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Release bounces keep the count; only a fresh press or a settled release clears it.
  always_comb begin
    hold_d = hold_q;
    if (state_d == StLow || (state_q == StArmH && state_d == StHigh)) begin
      hold_d = '0;
    end else if ((state_q == StHigh || state_q == StArmL) && hold_q != HoldMax) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign long_d = (hold_d == HoldMax) && (hold_q != HoldMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn.long_press = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_CYCLES;
  assign btn.long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: expected pulses (kind, cycle) are queued as stimulus
// is driven and compared against pulses captured by a negedge monitor.
module tb_debounce_edge;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  localparam int KRise = 0;
  localparam int KFall = 1;
  localparam int KLong = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  ev_t exp_q[$];
  ev_t obs_q[$];

  debounce_edge_if bus ();

  debounce_edge #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Outputs settle after posedge; negedge sampling sees the value produced by edge cyc.
  always @(negedge clk) begin
    if (bus.rise === 1'b1)       obs_q.push_back('{kind: KRise, cyc: cyc});
    if (bus.fall === 1'b1)       obs_q.push_back('{kind: KFall, cyc: cyc});
    if (bus.long_press === 1'b1) obs_q.push_back('{kind: KLong, cyc: cyc});
  end

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input driven now is first sampled at edge cyc+1; the pulse appears D edges later.
  task automatic expect_ev(input int kind, input int at);
    exp_q.push_back('{kind: kind, cyc: at});
  endtask

  task automatic drain(input string tag);
    ev_t e;
    ev_t o;
    check({tag, "_nev"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_kind"}, o.kind, e.kind);
      check({tag, "_cyc"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.in   = 1'b1;

    // Reset held two cycles with the button pressed, then the long hold.
    tick(1);
    check("rst_out",  int'(bus.out), 0);
    check("rst_rise", int'(bus.rise), 0);
    check("rst_fall", int'(bus.fall), 0);
    check("rst_long", int'(bus.long_press), 0);
    tick(1);
    check("rst2_out", int'(bus.out), 0);
    rst = 1'b0;
    expect_ev(KRise, cyc + 1 + D);
`ifdef DEBOUNCE_LONG_PRESS_EN
    expect_ev(KLong, cyc + 1 + D + L);
`endif
    tick(45);
    check("s1_out_hi", int'(bus.out), 1);
    bus.in = 1'b0;
    expect_ev(KFall, cyc + 1 + D);
    tick(10);
    check("s1_out_lo", int'(bus.out), 0);
    drain("s1");

    // Clean press and release.
    bus.in = 1'b1;
    expect_ev(KRise, cyc + 1 + D);
    tick(10);
    check("s2_out_hi", int'(bus.out), 1);
    bus.in = 1'b0;
    expect_ev(KFall, cyc + 1 + D);
    tick(10);
    check("s2_out_lo", int'(bus.out), 0);
    drain("s2");

    // Glitch 1,1,1,0 then 1x6: only the restarted window completes.
    bus.in = 1'b1;
    tick(3);
    check("s3_out_arm", int'(bus.out), 0);
    bus.in = 1'b0;
    tick(1);
    bus.in = 1'b1;
    expect_ev(KRise, cyc + 1 + D);
    tick(6);
    bus.in = 1'b0;
    expect_ev(KFall, cyc + 1 + D);
    tick(10);
    drain("s3");

    // Release bounce 0,0,1 while high: level holds, no pulses.
    bus.in = 1'b1;
    expect_ev(KRise, cyc + 1 + D);
    tick(10);
    bus.in = 1'b0;
    tick(2);
    bus.in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("s4_bounce_out", int'(bus.out), 1);
    end
    bus.in = 1'b0;
    expect_ev(KFall, cyc + 1 + D);
    tick(10);
    drain("s4");

    // Reset while ArmH with cnt=2: a fresh full window is needed afterwards.
    bus.in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("s5_rst_out", int'(bus.out), 0);
    check("s5_rst_rise", int'(bus.rise), 0);
    rst = 1'b0;
    expect_ev(KRise, cyc + 1 + D);
    tick(10);
    bus.in = 1'b0;
    expect_ev(KFall, cyc + 1 + D);
    tick(10);
    check("s5_out_lo", int'(bus.out), 0);
    drain("s5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
